// File: rtl/dice_result_display.sv
// rtl/dice_result_display.sv - two-digit seven-segment dice result display with spin animation
module dice_result_display #(
    parameter int ANIM_FRAMES = 6,
    parameter int STEP_CYCLES = 4,
    parameter int BLANK_LEAD  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       result_valid,
    input  logic [4:0] result,
    output logic       busy,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic [4:0] shown_value,
    output logic       error
);

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(ANIM_FRAMES - 1);

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ANIM = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    cap_q, cap_d;
    logic [SW-1:0] step_q, step_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          busy_q, busy_d;
    logic [6:0]    seg_tens_q, seg_tens_d;
    logic [6:0]    seg_ones_q, seg_ones_d;
    logic [4:0]    shown_q, shown_d;
    logic          error_q, error_d;

    logic          legal;
    logic [1:0]    cap_tens;
    logic [3:0]    cap_ones;
    logic [6:0]    cap_tens_seg;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'h40;
            4'd1:    digit_seg = 7'h79;
            4'd2:    digit_seg = 7'h24;
            4'd3:    digit_seg = 7'h30;
            4'd4:    digit_seg = 7'h19;
            4'd5:    digit_seg = 7'h12;
            4'd6:    digit_seg = 7'h02;
            4'd7:    digit_seg = 7'h78;
            4'd8:    digit_seg = 7'h00;
            4'd9:    digit_seg = 7'h18;
            default: digit_seg = SEG_BLANK;
        endcase
    endfunction

    // A single lit outer segment walks a..f, repeating every six frames.
    function automatic logic [6:0] spin_seg(input logic [FW-1:0] f);
        case (int'(f) % 6)
            0:       spin_seg = 7'h7E;
            1:       spin_seg = 7'h7D;
            2:       spin_seg = 7'h7B;
            3:       spin_seg = 7'h77;
            4:       spin_seg = 7'h6F;
            default: spin_seg = 7'h5F;
        endcase
    endfunction

    always_comb begin
        legal = result_valid && (result >= 5'd1) && (result <= 5'd20);

        if (cap_q >= 5'd20) begin
            cap_tens = 2'd2;
            cap_ones = 4'(cap_q - 5'd20);
        end else if (cap_q >= 5'd10) begin
            cap_tens = 2'd1;
            cap_ones = 4'(cap_q - 5'd10);
        end else begin
            cap_tens = 2'd0;
            cap_ones = cap_q[3:0];
        end
        cap_tens_seg = (cap_tens == 2'd0 && BLANK_LEAD != 0) ? SEG_BLANK : digit_seg({2'b00, cap_tens});

        state_d    = state_q;
        cap_d      = cap_q;
        step_d     = step_q;
        frame_d    = frame_q;
        busy_d     = busy_q;
        seg_tens_d = seg_tens_q;
        seg_ones_d = seg_ones_q;
        shown_d    = shown_q;
        error_d    = error_q;

        case (state_q)
            ST_ANIM: begin
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    if (frame_q == FRAME_LAST) begin
                        state_d    = ST_SHOW;
                        busy_d     = 1'b0;
                        shown_d    = cap_q;
                        seg_tens_d = cap_tens_seg;
                        seg_ones_d = digit_seg(cap_ones);
                    end else begin
                        frame_d    = frame_q + 1'b1;
                        seg_tens_d = spin_seg(frame_d);
                        seg_ones_d = spin_seg(frame_d);
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                if (legal) begin
                    state_d    = ST_ANIM;
                    cap_d      = result;
                    step_d     = '0;
                    frame_d    = '0;
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    seg_tens_d = spin_seg('0);
                    seg_ones_d = spin_seg('0);
                end else if (result_valid) begin
                    error_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cap_q      <= '0;
            step_q     <= '0;
            frame_q    <= '0;
            busy_q     <= 1'b0;
            seg_tens_q <= SEG_DASH;
            seg_ones_q <= SEG_DASH;
            shown_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            step_q     <= step_d;
            frame_q    <= frame_d;
            busy_q     <= busy_d;
            seg_tens_q <= seg_tens_d;
            seg_ones_q <= seg_ones_d;
            shown_q    <= shown_d;
            error_q    <= error_d;
        end
    end

    assign busy        = busy_q;
    assign seg_tens    = seg_tens_q;
    assign seg_ones    = seg_ones_q;
    assign shown_value = shown_q;
    assign error       = error_q;

endmodule

// File: tb/tb_dice_result_display.sv
// tb/tb_dice_result_display.sv - directed and random checks of dice_result_display against a behavioural model
module tb_dice_result_display;

    localparam int AF = 4;
    localparam int SC = 2;
    localparam int ANIM_LEN = AF * SC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       result_valid = 1'b0;
    logic [4:0] result = 5'd0;

    logic       busy_a, error_a, busy_b, error_b;
    logic [6:0] seg_tens_a, seg_ones_a, seg_tens_b, seg_ones_b;
    logic [4:0] shown_a, shown_b;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: busy flag plus cycles elapsed inside the animation.
    bit m_busy = 1'b0;
    int m_cyc = 0;
    int m_cap = 0;
    int m_shown = 0;
    bit m_err = 1'b0;

    logic [6:0] spin_tab [6];
    logic [6:0] dig_tab [10];

    dice_result_display #(.ANIM_FRAMES(AF), .STEP_CYCLES(SC), .BLANK_LEAD(1)) dut_a (
        .clk(clk), .reset(reset), .result_valid(result_valid), .result(result),
        .busy(busy_a), .seg_tens(seg_tens_a), .seg_ones(seg_ones_a),
        .shown_value(shown_a), .error(error_a)
    );

    dice_result_display #(.ANIM_FRAMES(AF), .STEP_CYCLES(SC), .BLANK_LEAD(0)) dut_b (
        .clk(clk), .reset(reset), .result_valid(result_valid), .result(result),
        .busy(busy_b), .seg_tens(seg_tens_b), .seg_ones(seg_ones_b),
        .shown_value(shown_b), .error(error_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_tens(input bit blank);
        if (m_busy) return spin_tab[(m_cyc / SC) % 6];
        if (m_shown == 0) return 7'h3F;
        if (m_shown < 10) return blank ? 7'h7F : dig_tab[0];
        return dig_tab[m_shown / 10];
    endfunction

    function automatic logic [6:0] exp_ones();
        if (m_busy) return spin_tab[(m_cyc / SC) % 6];
        if (m_shown == 0) return 7'h3F;
        return dig_tab[m_shown % 10];
    endfunction

    task automatic model_step(input bit r, input bit v, input int res);
        if (r) begin
            m_busy = 1'b0; m_cyc = 0; m_shown = 0; m_err = 1'b0;
        end else if (m_busy) begin
            m_cyc++;
            if (m_cyc == ANIM_LEN) begin
                m_busy = 1'b0;
                m_shown = m_cap;
            end
        end else if (v) begin
            if (res >= 1 && res <= 20) begin
                m_cap = res; m_busy = 1'b1; m_cyc = 0; m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        chk("busy", 7'(busy_a), 7'(m_busy));
        chk("error", 7'(error_a), 7'(m_err));
        chk("shown", 7'(shown_a), 7'(m_shown));
        chk("seg_tens", seg_tens_a, exp_tens(1'b1));
        chk("seg_ones", seg_ones_a, exp_ones());
        chk("b_seg_tens", seg_tens_b, exp_tens(1'b0));
        chk("b_seg_ones", seg_ones_b, exp_ones());
    endtask

    task automatic tick(input bit r, input bit v, input logic [4:0] res);
        reset = r;
        result_valid = v;
        result = res;
        @(posedge clk);
        model_step(r, v, int'(res));
        #1;
        check_model();
    endtask

    initial begin
        spin_tab = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F};
        dig_tab  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
        @(negedge clk);

        tick(1'b1, 1'b0, 5'd0);
        chk("rst_tens", seg_tens_a, 7'h3F);
        chk("rst_ones", seg_ones_a, 7'h3F);
        chk("rst_busy", 7'(busy_a), 7'd0);
        chk("rst_shown", 7'(shown_a), 7'd0);
        chk("rst_error", 7'(error_a), 7'd0);

        tick(1'b0, 1'b1, 5'd7);
        chk("r7_busy", 7'(busy_a), 7'd1);
        chk("r7_spin", seg_ones_a, 7'h7E);
        repeat (ANIM_LEN - 1) tick(1'b0, 1'b0, 5'd0);
        chk("r7_still_busy", 7'(busy_a), 7'd1);
        tick(1'b0, 1'b0, 5'd0);
        chk("r7_tens", seg_tens_a, 7'h7F);
        chk("r7_ones", seg_ones_a, 7'h78);
        chk("r7_shown", 7'(shown_a), 7'd7);
        chk("r7_busy_end", 7'(busy_a), 7'd0);

        tick(1'b0, 1'b1, 5'd20);
        repeat (ANIM_LEN) tick(1'b0, 1'b0, 5'd0);
        chk("r20_tens", seg_tens_a, 7'h24);
        chk("r20_ones", seg_ones_a, 7'h40);

        tick(1'b0, 1'b1, 5'd3);
        repeat (ANIM_LEN) tick(1'b0, 1'b0, 5'd0);
        chk("r3_nb_tens", seg_tens_b, 7'h40);
        chk("r3_nb_ones", seg_ones_b, 7'h30);
        chk("r3_bl_tens", seg_tens_a, 7'h7F);

        tick(1'b0, 1'b1, 5'd5);
        for (int i = 1; i < ANIM_LEN; i++) tick(1'b0, (i == 3), 5'd15);
        chk("ign_busy", 7'(busy_a), 7'd1);
        tick(1'b0, 1'b0, 5'd0);
        chk("ign_busy_end", 7'(busy_a), 7'd0);
        chk("ign_shown", 7'(shown_a), 7'd5);

        tick(1'b1, 1'b0, 5'd0);
        tick(1'b0, 1'b1, 5'd0);
        chk("err0", 7'(error_a), 7'd1);
        chk("err0_tens", seg_tens_a, 7'h3F);
        tick(1'b0, 1'b1, 5'd21);
        chk("err21", 7'(error_a), 7'd1);
        chk("err21_ones", seg_ones_a, 7'h3F);
        tick(1'b0, 1'b1, 5'd12);
        chk("err_clr", 7'(error_a), 7'd0);
        repeat (ANIM_LEN) tick(1'b0, 1'b0, 5'd0);
        chk("r12_tens", seg_tens_a, 7'h79);
        chk("r12_ones", seg_ones_a, 7'h24);

        tick(1'b0, 1'b1, 5'd9);
        repeat (3) tick(1'b0, 1'b0, 5'd0);
        tick(1'b1, 1'b0, 5'd0);
        chk("rst_anim_tens", seg_tens_a, 7'h3F);
        chk("rst_anim_busy", 7'(busy_a), 7'd0);
        repeat (ANIM_LEN + 2) tick(1'b0, 1'b0, 5'd0);
        chk("rst_anim_noshow", 7'(shown_a), 7'd0);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] res;
            bit v, r;
            r = ($urandom_range(63) == 0);
            v = ($urandom_range(3) == 0);
            res = ($urandom_range(3) != 0) ? 5'($urandom_range(20, 1)) : 5'($urandom_range(31));
            tick(r, v, res);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
